lockout_timer: RTL and testbench



---
 rtl/lockout_timer_pkg.sv | 54 +++++
 rtl/lockout_timer_bcd_down_counter.sv | 53 +++++
 rtl/lockout_timer.sv | 123 ++++++++++++
 tb/tb_lockout_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lockout_timer_pkg.sv
// Shared lock definitions: FSM state encoding, active-low seven-segment
// patterns (segments a..g in bits [0:6]) and the default lockout length.
package lockout_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EXPIRE = 2'd2
    } state_e;

    localparam int unsigned BCD_W                = 4;
    localparam int unsigned SEG_W                = 7;
    localparam int unsigned LOCK_SECONDS_DEFAULT = 30;

    typedef logic [0:SEG_W-1] seg_t;

    // Two-digit BCD value, tens in the upper nibble.
    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // BCD digit to active-low segment pattern; non-BCD codes blank the digit.
    function automatic seg_t bcd_to_seg(input logic [BCD_W-1:0] d);
        seg_t s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lockout_timer_bcd_down_counter.sv
// Two-digit BCD down counter with load and borrow (ones 0 -> 9, tens
// decrements). Exposes the look-ahead value the register takes at the next
// edge so the owner can register display patterns without an extra cycle.
//   clk, rst     : clock, synchronous active-high reset (value -> 00)
//   load/load_val: load a BCD value (has priority over dec)
//   dec          : decrement by one
//   tens_nxt_c, ones_nxt_c : value after the coming edge
//   zero_nxt_c   : that value is 00
module lockout_timer_bcd_down_counter
    import lockout_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  bcd2_t            load_val,
    input  logic             dec,
    output logic [BCD_W-1:0] tens_nxt_c,
    output logic [BCD_W-1:0] ones_nxt_c,
    output logic             zero_nxt_c
);

    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] ones_q;

    // Next-value logic: load, else decrement with borrow, else hold.
    always_comb begin
        tens_nxt_c = tens_q;
        ones_nxt_c = ones_q;
        if (load) begin
            tens_nxt_c = load_val.tens;
            ones_nxt_c = load_val.ones;
        end else if (dec) begin
            if (ones_q == 4'd0) begin
                ones_nxt_c = 4'd9;
                tens_nxt_c = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            end else begin
                ones_nxt_c = ones_q - 4'd1;
            end
        end
        zero_nxt_c = (tens_nxt_c == 4'd0) && (ones_nxt_c == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_nxt_c;
            ones_q <= ones_nxt_c;
        end
    end

endmodule

// File: rtl/lockout_timer.sv
// Lockout countdown: on start, counts LOCK_SECONDS whole seconds down to 00
// (one second = TICK_DIV clocks), shows the value on two active-low digits,
// and pulses done for one cycle at expiry.
//   clk, rst       : clock, synchronous active-high reset
//   start          : load LOCK_SECONDS and (re)start the countdown
//   abort          : cancel a running countdown without done
//   active         : high while counting
//   done           : one-cycle expiry pulse
//   hexten, hexone : tens / ones segment patterns a..g, active-low
module lockout_timer
    import lockout_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned LOCK_SECONDS = LOCK_SECONDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       active,
    output logic       done,
    output logic [0:6] hexten,
    output logic [0:6] hexone
);

    if (TICK_DIV < 2 || LOCK_SECONDS < 1 || LOCK_SECONDS > 99) begin : g_bad_param
        $error("lockout_timer: TICK_DIV must be >= 2 and LOCK_SECONDS in 1..99");
    end

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam bcd2_t         LOAD_VAL   = '{tens: 4'(LOCK_SECONDS / 10),
                                             ones: 4'(LOCK_SECONDS % 10)};

    state_e           state;
    logic [PW-1:0]    presc;
    logic             tick_c;
    logic             load_c;
    logic             dec_c;
    logic [BCD_W-1:0] tens_nxt_c;
    logic [BCD_W-1:0] ones_nxt_c;
    logic             zero_nxt_c;

    // Counter controls: abort beats start in COUNT, start reloads, tick decrements.
    always_comb begin
        tick_c = (presc == PRESC_LAST);
        load_c = 1'b0;
        dec_c  = 1'b0;
        if (state == ST_IDLE) begin
            load_c = start;
        end else if (state == ST_COUNT && !abort) begin
            load_c = start;
            dec_c  = !start && tick_c;
        end
    end

    lockout_timer_bcd_down_counter u_bcd (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .load_val   (LOAD_VAL),
        .dec        (dec_c),
        .tens_nxt_c (tens_nxt_c),
        .ones_nxt_c (ones_nxt_c),
        .zero_nxt_c (zero_nxt_c)
    );

    // FSM, prescaler and registered outputs; digits track the counter's next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            presc  <= '0;
            active <= 1'b0;
            done   <= 1'b0;
            hexten <= SEG_BLANK;
            hexone <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_COUNT;
                        presc  <= '0;
                        active <= 1'b1;
                        hexten <= bcd_to_seg(tens_nxt_c);
                        hexone <= bcd_to_seg(ones_nxt_c);
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                        hexten <= SEG_BLANK;
                        hexone <= SEG_BLANK;
                    end else begin
                        presc  <= (start || tick_c) ? '0 : presc + PW'(1);
                        hexten <= bcd_to_seg(tens_nxt_c);
                        hexone <= bcd_to_seg(ones_nxt_c);
                        // Decrement from 01 lands on 00: expire.
                        if (dec_c && zero_nxt_c) begin
                            state  <= ST_EXPIRE;
                            active <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end
                ST_EXPIRE: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                    hexten <= SEG_BLANK;
                    hexone <= SEG_BLANK;
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                    hexten <= SEG_BLANK;
                    hexone <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockout_timer.sv
// Bench for lockout_timer: table of per-edge vectors for the main countdown
// and input interactions, plus hand sequences for restart, abort, mid-count
// reset and a tens-borrow run on a second instance (TICK_DIV=2, 12 s).
module tb_lockout_timer;

    logic       clk = 1'b0;
    logic       rst, start, abort, start2, abort2;
    logic       active, done, active2, done2;
    logic [0:6] hexten, hexone, hexten2, hexone2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] BL = 7'b1111111;

    typedef struct {
        logic       start;
        logic       abort;
        logic       active;
        logic       done;
        logic [6:0] ten;
        logic [6:0] one;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    lockout_timer #(.TICK_DIV(4), .LOCK_SECONDS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .active(active), .done(done), .hexten(hexten), .hexone(hexone)
    );

    lockout_timer #(.TICK_DIV(2), .LOCK_SECONDS(12)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .active(active2), .done(done2), .hexten(hexten2), .hexone(hexone2)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return BL;
        endcase
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Present inputs for one rising edge, then sample 1 time unit after it.
    task automatic edge_with(input logic s, input logic a);
        start = s;
        abort = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input logic s, input logic a, input logic act, input logic dn,
                       input logic [6:0] t, input logic [6:0] o);
        vec_t v;
        v.start = s; v.abort = a; v.active = act; v.done = dn; v.ten = t; v.one = o;
        vecs.push_back(v);
    endtask

    initial begin
        logic saw_done;

        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;

        // Vector k: inputs sampled at edge k, expectations for cycle k+1.
        add(1, 0, 1, 0, seg(0), seg(3));
        for (int i = 1; i <= 3;  i++) add(0, 0, 1, 0, seg(0), seg(3));
        for (int i = 4; i <= 7;  i++) add(0, 0, 1, 0, seg(0), seg(2));
        for (int i = 8; i <= 11; i++) add(0, 0, 1, 0, seg(0), seg(1));
        add(0, 0, 0, 1, seg(0), seg(0));   // cycle 13: expiry
        add(0, 0, 0, 0, BL, BL);           // cycle 14: blank
        add(0, 1, 0, 0, BL, BL);           // abort in IDLE: no effect
        add(1, 0, 1, 0, seg(0), seg(3));   // start
        add(1, 1, 0, 0, BL, BL);           // start+abort in COUNT: abort wins
        add(1, 1, 1, 0, seg(0), seg(3));   // start+abort in IDLE: start wins
        add(0, 0, 1, 0, seg(0), seg(3));
        add(0, 1, 0, 0, BL, BL);           // abort
        add(0, 0, 0, 0, BL, BL);

        // Reset state and idle behaviour.
        do_reset();
        chk("reset active", 7'(active), 7'd0);
        chk("reset done", 7'(done), 7'd0);
        chk("reset hexten", hexten, BL);
        chk("reset hexone", hexone, BL);
        for (int i = 0; i < 20; i++) begin
            edge_with(0, 0);
            chk($sformatf("idle%0d active", i), 7'(active), 7'd0);
            chk($sformatf("idle%0d done", i), 7'(done), 7'd0);
            chk($sformatf("idle%0d hexten", i), hexten, BL);
            chk($sformatf("idle%0d hexone", i), hexone, BL);
        end

        // Main table.
        do_reset();
        for (int k = 0; k < vecs.size(); k++) begin
            edge_with(vecs[k].start, vecs[k].abort);
            chk($sformatf("vec%0d active", k), 7'(active), 7'(vecs[k].active));
            chk($sformatf("vec%0d done", k), 7'(done), 7'(vecs[k].done));
            chk($sformatf("vec%0d hexten", k), hexten, vecs[k].ten);
            chk($sformatf("vec%0d hexone", k), hexone, vecs[k].one);
        end

        // Restart at edge 6: display back to 3, done in cycle 19 only.
        do_reset();
        edge_with(1, 0);
        for (int c = 2; c <= 6; c++) edge_with(0, 0);
        chk("restart pre hexone", hexone, seg(2));
        edge_with(1, 0);
        chk("restart hexten", hexten, seg(0));
        chk("restart hexone", hexone, seg(3));
        for (int c = 8; c <= 19; c++) begin
            edge_with(0, 0);
            chk($sformatf("restart c%0d done", c), 7'(done), 7'(c == 19));
        end

        // Abort at edge 6: blank in cycle 7, no done afterwards.
        do_reset();
        edge_with(1, 0);
        for (int c = 2; c <= 6; c++) edge_with(0, 0);
        edge_with(0, 1);
        chk("abort hexten", hexten, BL);
        chk("abort hexone", hexone, BL);
        chk("abort active", 7'(active), 7'd0);
        saw_done = done;
        for (int i = 0; i < 30; i++) begin
            edge_with(0, 0);
            saw_done |= done;
        end
        chk("abort no done", 7'(saw_done), 7'd0);

        // Reset at edge 7 mid-count.
        do_reset();
        edge_with(1, 0);
        for (int c = 2; c <= 7; c++) edge_with(0, 0);
        chk("midrst pre active", 7'(active), 7'd1);
        rst = 1'b1;
        edge_with(0, 0);
        rst = 1'b0;
        chk("midrst hexten", hexten, BL);
        chk("midrst hexone", hexone, BL);
        chk("midrst active", 7'(active), 7'd0);
        saw_done = done;
        for (int i = 0; i < 30; i++) begin
            edge_with(0, 0);
            saw_done |= done;
        end
        chk("midrst no done", 7'(saw_done), 7'd0);

        // Tens borrow on the 12 s / TICK_DIV=2 instance.
        do_reset();
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            logic [6:0] et, eo;
            logic       ed, ea;
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c <= 24) begin
                int v;
                v  = 12 - (c - 1) / 2;
                et = seg(v / 10); eo = seg(v % 10); ed = 1'b0; ea = 1'b1;
            end else if (c == 25) begin
                et = seg(0); eo = seg(0); ed = 1'b1; ea = 1'b0;
            end else begin
                et = BL; eo = BL; ed = 1'b0; ea = 1'b0;
            end
            chk($sformatf("borrow c%0d hexten", c), hexten2, et);
            chk($sformatf("borrow c%0d hexone", c), hexone2, eo);
            chk($sformatf("borrow c%0d done", c), 7'(done2), 7'(ed));
            chk($sformatf("borrow c%0d active", c), 7'(active2), 7'(ea));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
